// File: rtl/simon_seq_engine.sv
// ---------------------------------------------------------------------------
// simon_seq_engine
//
// Sequence engine for a Simon-style memory game. Each round it samples one
// colour from the random source and appends it to an on-chip buffer. It then
// replays the whole buffer on the LEDs with fixed on/gap timing, and checks
// the player's button presses against it.
//
// Ports:
//   clk            single clock
//   rst            synchronous, active-high reset
//   start          begin a new game (honoured only in IDLE, FAIL and WIN)
//   random_seq     colour from the random source, sampled only while appending
//   btn_valid      one-cycle pulse per player press
//   btn_code       colour of the press, valid with btn_valid
//   led_valid      high while a colour is being shown
//   led_code       colour being shown, 0 while led_valid is low
//   awaiting_input high while the engine waits for the player's presses
//   round_pass     one-cycle pulse when a round (other than the last) is won
//   game_over      level, high after a wrong press or a timeout
//   win            level, high after the final round is passed
//   round          current sequence length
// ---------------------------------------------------------------------------
module simon_seq_engine #(
    parameter int MAX_LEN        = 16,
    parameter int ON_CYCLES      = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [1:0]                   random_seq,
    input  logic                         btn_valid,
    input  logic [1:0]                   btn_code,
    output logic                         led_valid,
    output logic [1:0]                   led_code,
    output logic                         awaiting_input,
    output logic                         round_pass,
    output logic                         game_over,
    output logic                         win,
    output logic [$clog2(MAX_LEN+1)-1:0] round
);

    localparam int LW    = $clog2(MAX_LEN + 1);
    localparam int IW    = $clog2(MAX_LEN);
    localparam int DEPTH = 2 ** IW;
    localparam int TMAX0 = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int TMAX  = (TMAX0 > TIMEOUT_CYCLES) ? TMAX0 : TIMEOUT_CYCLES;
    localparam int TW    = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        APPEND,
        PLAY_ON,
        PLAY_GAP,
        WAIT_INPUT,
        PASS,
        FAIL,
        WIN
    } state_t;

    state_t        state, state_next;
    logic [LW-1:0] len, len_next;
    logic [IW-1:0] idx, idx_next;
    logic [TW-1:0] timer, timer_next;
    logic [1:0]    mem [DEPTH];
    logic [1:0]    mem_code;
    logic          last_idx;

    // The single timer is shared: it counts the on/gap periods during
    // playback and the idle cycles while waiting for a press.
    assign mem_code = mem[idx];
    assign last_idx = (LW'(idx) == (len - LW'(1)));

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            len   <= '0;
            idx   <= '0;
            timer <= '0;
        end else begin
            state <= state_next;
            len   <= len_next;
            idx   <= idx_next;
            timer <= timer_next;
        end
    end

    // The sequence buffer has no reset. Entries at or above len are never
    // read, so stale contents from an earlier game are harmless.
    always_ff @(posedge clk) begin
        if (state == APPEND) begin
            mem[len[IW-1:0]] <= random_seq;
        end
    end

    // Next-state logic. A press that arrives on the cycle the timeout would
    // expire takes priority over the timeout.
    always_comb begin
        state_next = state;
        len_next   = len;
        idx_next   = idx;
        timer_next = timer;
        case (state)
            IDLE, FAIL, WIN: begin
                if (start) begin
                    len_next   = '0;
                    state_next = APPEND;
                end
            end
            APPEND: begin
                len_next   = len + LW'(1);
                idx_next   = '0;
                timer_next = '0;
                state_next = PLAY_ON;
            end
            PLAY_ON: begin
                if (timer == TW'(ON_CYCLES - 1)) begin
                    timer_next = '0;
                    state_next = PLAY_GAP;
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            PLAY_GAP: begin
                if (timer == TW'(GAP_CYCLES - 1)) begin
                    timer_next = '0;
                    if (last_idx) begin
                        idx_next   = '0;
                        state_next = WAIT_INPUT;
                    end else begin
                        idx_next   = idx + IW'(1);
                        state_next = PLAY_ON;
                    end
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            WAIT_INPUT: begin
                if (btn_valid) begin
                    if (btn_code == mem_code) begin
                        if (last_idx) begin
                            state_next = (len == LW'(MAX_LEN)) ? WIN : PASS;
                        end else begin
                            idx_next   = idx + IW'(1);
                            timer_next = '0;
                        end
                    end else begin
                        state_next = FAIL;
                    end
                end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_next = FAIL;
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            PASS: begin
                state_next = APPEND;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // All outputs are decoded from the registered state, so a reset edge
    // clears them immediately with no partial LED pulse.
    always_comb begin
        led_valid      = (state == PLAY_ON);
        led_code       = (state == PLAY_ON) ? mem_code : 2'b00;
        awaiting_input = (state == WAIT_INPUT);
        round_pass     = (state == PASS);
        game_over      = (state == FAIL);
        win            = (state == WIN);
        round          = len;
    end

endmodule
